// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal slices, one per register rank.
// Zero_o/Neg_o flag logic exists only when PIPELINED_ADD_SUB_FLAGS_EN is defined; otherwise both are tied low.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  input  logic             Sel_i,
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic [WIDTH-1:0] Sum_o,
  output logic             C_o,
  output logic             Overflow_o,
  output logic             Zero_o,
  output logic             Neg_o
);

  localparam int SLICE_W = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;
  localparam int REM     = (STAGES >= 1) ? WIDTH % STAGES : 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || REM != 0) begin : g_param_err
    $error("pipelined_add_sub: illegal WIDTH/STAGES combination");
  end

  logic stall;

  assign stall   = Valid_o & ~Ready_i;
  assign Ready_o = ~stall | Rst_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int IN_W  = WIDTH - k * SLICE_W;
    localparam int OUT_W = (k + 1) * SLICE_W;

    logic [IN_W-1:0]    a_in;
    logic [IN_W-1:0]    b_in;
    logic               c_in;
    logic               sel_in;
    logic               vld_in;
    logic [SLICE_W-1:0] bx;
    logic [SLICE_W:0]   slice;
    logic [OUT_W-1:0]   sum_d;
    logic [OUT_W-1:0]   sum_q;
    logic               cy_q;
    logic               vld_q;

    // Stage 0 takes the ports directly; a borrow-in becomes carry-in = ~C_i when subtracting.
    if (k == 0) begin : g_first
      assign a_in   = A_i;
      assign b_in   = B_i;
      assign c_in   = C_i ^ Sel_i;
      assign sel_in = Sel_i;
      assign vld_in = Valid_i;
      assign sum_d  = slice[SLICE_W-1:0];
    end else begin : g_next
      assign a_in   = g_stg[k-1].g_ops.a_q;
      assign b_in   = g_stg[k-1].g_ops.b_q;
      assign c_in   = g_stg[k-1].cy_q;
      assign sel_in = g_stg[k-1].g_ops.sel_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign sum_d  = {slice[SLICE_W-1:0], g_stg[k-1].sum_q};
    end

    assign bx    = b_in[SLICE_W-1:0] ^ {SLICE_W{sel_in}};
    assign slice = {1'b0, a_in[SLICE_W-1:0]} + {1'b0, bx} + {{SLICE_W{1'b0}}, c_in};

    always_ff @(posedge Clk_i) begin
      if (Rst_i)       vld_q <= 1'b0;
      else if (!stall) vld_q <= vld_in;
    end

    if (k < STAGES - 1) begin : g_ops
      logic [IN_W-SLICE_W-1:0] a_q;
      logic [IN_W-SLICE_W-1:0] b_q;
      logic                    sel_q;

      // ---- stage k -> k+1: partial sum, slice carry, unconsumed operand bits ----
      always_ff @(posedge Clk_i) begin
        if (!stall) begin
          sum_q <= sum_d;
          cy_q  <= slice[SLICE_W];
          a_q   <= a_in[IN_W-1:SLICE_W];
          b_q   <= b_in[IN_W-1:SLICE_W];
          sel_q <= sel_in;
        end
      end
    end else begin : g_last
      logic cy_into_msb;
      logic ovf_q;

      assign cy_into_msb = a_in[SLICE_W-1] ^ bx[SLICE_W-1] ^ slice[SLICE_W-1];

      // ---- final stage -> outputs ----
      always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
          sum_q <= '0;
          cy_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else if (!stall) begin
          sum_q <= sum_d;
          cy_q  <= slice[SLICE_W];
          ovf_q <= cy_into_msb ^ slice[SLICE_W];
        end
      end

`ifdef PIPELINED_ADD_SUB_FLAGS_EN
      logic zero_q;
      logic neg_q;

      always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (!stall) begin
          zero_q <= ~|sum_d;
          neg_q  <= sum_d[OUT_W-1];
        end
      end
`endif
    end
  end

  assign Valid_o    = g_stg[STAGES-1].vld_q;
  assign Sum_o      = g_stg[STAGES-1].sum_q;
  assign C_o        = g_stg[STAGES-1].cy_q;
  assign Overflow_o = g_stg[STAGES-1].g_last.ovf_q;

`ifdef PIPELINED_ADD_SUB_FLAGS_EN
  assign Zero_o = g_stg[STAGES-1].g_last.zero_q;
  assign Neg_o  = g_stg[STAGES-1].g_last.neg_q;
`else
  assign Zero_o = 1'b0;
  assign Neg_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: a 32-bit/4-stage instance and an 8-bit/1-stage instance.
module tb_pipelined_add_sub;

`ifdef PIPELINED_ADD_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        Clk_i = 1'b0;
  logic        Rst_i = 1'b1;
  logic        Valid_i = 1'b0;
  logic        Ready_o;
  logic [31:0] A_i = '0;
  logic [31:0] B_i = '0;
  logic        C_i = 1'b0;
  logic        Sel_i = 1'b0;
  logic        Valid_o;
  logic        Ready_i = 1'b1;
  logic [31:0] Sum_o;
  logic        C_o, Overflow_o, Zero_o, Neg_o;

  logic        vld8_i = 1'b0;
  logic        rdy8_o;
  logic [7:0]  a8_i = '0;
  logic [7:0]  b8_i = '0;
  logic        c8_i = 1'b0;
  logic        sel8_i = 1'b0;
  logic        vld8_o;
  logic        rdy8_i = 1'b1;
  logic [7:0]  sum8_o;
  logic        c8_o, ovf8_o, zero8_o, neg8_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk_i = ~Clk_i;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Valid_i(Valid_i), .Ready_o(Ready_o),
    .A_i(A_i), .B_i(B_i), .C_i(C_i), .Sel_i(Sel_i),
    .Valid_o(Valid_o), .Ready_i(Ready_i), .Sum_o(Sum_o), .C_o(C_o),
    .Overflow_o(Overflow_o), .Zero_o(Zero_o), .Neg_o(Neg_o)
  );

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Valid_i(vld8_i), .Ready_o(rdy8_o),
    .A_i(a8_i), .B_i(b8_i), .C_i(c8_i), .Sel_i(sel8_i),
    .Valid_o(vld8_o), .Ready_i(rdy8_i), .Sum_o(sum8_o), .C_o(c8_o),
    .Overflow_o(ovf8_o), .Zero_o(zero8_o), .Neg_o(neg8_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic sel, input logic [31:0] exp_sum,
                        input logic exp_c, input logic exp_ovf, input logic exp_z,
                        input logic exp_n);
    A_i = a; B_i = b; C_i = c; Sel_i = sel; Valid_i = 1'b1;
    step();
    Valid_i = 1'b0; A_i = '1; B_i = '1; C_i = ~c; Sel_i = ~sel;
    step();
    step();
    check({tag, "_early"}, Valid_o, 1'b0);
    step();
    check({tag, "_vld"}, Valid_o, 1'b1);
    check({tag, "_sum"}, Sum_o, exp_sum);
    check({tag, "_c"}, C_o, exp_c);
    check({tag, "_ovf"}, Overflow_o, exp_ovf);
    check({tag, "_zero"}, Zero_o, exp_z);
    check({tag, "_neg"}, Neg_o, exp_n);
    step();
    check({tag, "_bubble"}, Valid_o, 1'b0);
  endtask

  // 8 adds i + 0xFFFF; toggle=0: Ready_i low in cycles 5..7, toggle=1: Ready_i alternates.
  task automatic stream(input string tag, input bit toggle);
    int tx = 0;
    int rx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      Ready_i = toggle ? cyc[0] : !(cyc >= 5 && cyc <= 7);
      #1;
      if (!toggle && cyc <= 12)
        check($sformatf("%s_rdy%0d", tag, cyc), Ready_o, (cyc >= 5 && cyc <= 7) ? 1'b0 : 1'b1);
      if (Valid_o) begin
        if (rx < 8) begin
          check($sformatf("%s_res%0d", tag, rx), Sum_o, 32'h0000FFFF + 32'(rx));
          if (Ready_i) rx++;
        end else begin
          check({tag, "_extra"}, Valid_o, 1'b0);
        end
      end
      if (tx < 8) begin
        Valid_i = 1'b1; A_i = 32'(tx); B_i = 32'h0000FFFF; C_i = 1'b0; Sel_i = 1'b0;
        if (Ready_o) tx++;
      end else begin
        Valid_i = 1'b0;
      end
      step();
    end
    Valid_i = 1'b0;
    Ready_i = 1'b1;
    check({tag, "_count"}, rx, 8);
  endtask

  initial begin
    int ghosts;
    step();
    step();
    check("rst_vld", Valid_o, 1'b0);
    check("rst_sum", Sum_o, 32'h0);
    check("rst_c", C_o, 1'b0);
    check("rst_ovf", Overflow_o, 1'b0);
    check("rst_zero", Zero_o, 1'b0);
    check("rst_neg", Neg_o, 1'b0);
    check("rst_rdy", Ready_o, 1'b1);
    check("rst_vld8", vld8_o, 1'b0);
    Rst_i = 1'b0;
    step();

    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, FLAGS, 1'b0);
    run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("sub_neg", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, FLAGS);
    run_op("add_cin", 32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_bin", 32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_povf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, FLAGS);

    stream("stall", 1'b0);
    step();
    stream("toggle", 1'b1);
    step();

    for (int i = 0; i < 3; i++) begin
      A_i = 32'(i + 10); B_i = 32'h1; C_i = 1'b0; Sel_i = 1'b0; Valid_i = 1'b1;
      step();
    end
    A_i = 32'h55; Valid_i = 1'b1; Rst_i = 1'b1;
    #1;
    check("rstmid_rdy_during", Ready_o, 1'b1);
    step();
    Rst_i = 1'b0; Valid_i = 1'b0;
    check("rstmid_vld", Valid_o, 1'b0);
    check("rstmid_sum", Sum_o, 32'h0);
    check("rstmid_rdy", Ready_o, 1'b1);
    ghosts = 0;
    for (int i = 0; i < 8; i++) begin
      if (Valid_o) ghosts++;
      step();
    end
    check("rstmid_ghosts", ghosts, 0);
    run_op("post_rst", 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);

    a8_i = 8'h7F; b8_i = 8'h01; c8_i = 1'b0; sel8_i = 1'b0; vld8_i = 1'b1;
    step();
    vld8_i = 1'b0;
    check("w8_vld", vld8_o, 1'b1);
    check("w8_sum", sum8_o, 8'h80);
    check("w8_ovf", ovf8_o, 1'b1);
    check("w8_c", c8_o, 1'b0);
    check("w8_zero", zero8_o, 1'b0);
    check("w8_neg", neg8_o, FLAGS);
    step();
    check("w8_bubble", vld8_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
